// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive front end.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_LSHIFT = 8'h12;
   localparam logic [7:0] PS2_RSHIFT = 8'h59;
   localparam logic [7:0] PS2_CAPS   = 8'h58;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   typedef struct packed {
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } ps2_event_t;

   // PS/2 uses odd parity: data bits plus parity bit must XOR to 1.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

   // True for 'A'..'Z' and 'a'..'z'; caps lock only affects these.
   function automatic logic is_alpha(input logic [7:0] ch);
      return ((ch >= 8'h41) && (ch <= 8'h5A)) || ((ch >= 8'h61) && (ch <= 8'h7A));
   endfunction

endpackage

// File: rtl/ps2_set2_ascii.sv
// Scan code set 2 to ASCII lookup (US layout subset). Unmapped codes give 0x00.
// Only compiled into the design when PS2_ASCII_EN is defined.
module ps2_set2_ascii
   import ps2_pkg::*;
(
   input  logic [7:0] code,
   input  logic       shift,
   output logic [7:0] ascii
);

   logic [15:0] pair_s;   // {unshifted, shifted}

   // Table lookup, then pick the shifted or unshifted half
   always_comb begin
      pair_s = 16'h0000;
      case (code)
         8'h1C: pair_s = 16'h6141;  8'h32: pair_s = 16'h6242;
         8'h21: pair_s = 16'h6343;  8'h23: pair_s = 16'h6444;
         8'h24: pair_s = 16'h6545;  8'h2B: pair_s = 16'h6646;
         8'h34: pair_s = 16'h6747;  8'h33: pair_s = 16'h6848;
         8'h43: pair_s = 16'h6949;  8'h3B: pair_s = 16'h6A4A;
         8'h42: pair_s = 16'h6B4B;  8'h4B: pair_s = 16'h6C4C;
         8'h3A: pair_s = 16'h6D4D;  8'h31: pair_s = 16'h6E4E;
         8'h44: pair_s = 16'h6F4F;  8'h4D: pair_s = 16'h7050;
         8'h15: pair_s = 16'h7151;  8'h2D: pair_s = 16'h7252;
         8'h1B: pair_s = 16'h7353;  8'h2C: pair_s = 16'h7454;
         8'h3C: pair_s = 16'h7555;  8'h2A: pair_s = 16'h7656;
         8'h1D: pair_s = 16'h7757;  8'h22: pair_s = 16'h7858;
         8'h35: pair_s = 16'h7959;  8'h1A: pair_s = 16'h7A5A;
         8'h45: pair_s = 16'h3029;  8'h16: pair_s = 16'h3121;
         8'h1E: pair_s = 16'h3240;  8'h26: pair_s = 16'h3323;
         8'h25: pair_s = 16'h3424;  8'h2E: pair_s = 16'h3525;
         8'h36: pair_s = 16'h365E;  8'h3D: pair_s = 16'h3726;
         8'h3E: pair_s = 16'h382A;  8'h46: pair_s = 16'h3928;
         8'h29: pair_s = 16'h2020;  8'h5A: pair_s = 16'h0D0D;
         8'h66: pair_s = 16'h0808;  8'h0D: pair_s = 16'h0909;
         8'h76: pair_s = 16'h1B1B;  8'h4E: pair_s = 16'h2D5F;
         8'h55: pair_s = 16'h3D2B;  8'h41: pair_s = 16'h2C3C;
         8'h49: pair_s = 16'h2E3E;  8'h4A: pair_s = 16'h2F3F;
         default: pair_s = 16'h0000;
      endcase
      if (shift) begin
         ascii = pair_s[7:0];
      end else begin
         ascii = pair_s[15:8];
      end
   end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise and filter the pins, deserialise
// 11-bit frames, fold E0/F0 prefixes into one event and queue events in a
// show-ahead FIFO for the MCU keyboard port.
// Optional macro PS2_ASCII_EN adds shift/caps tracking and an ASCII field.
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT_US = 1000
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd_en,
   output logic       rd_valid,
   output logic [7:0] rd_code,
   output logic       rd_brk,
   output logic       rd_ext,
   output logic [7:0] rd_ascii,
   output logic       overflow,
   output logic       frame_err,
   input  logic       clr_err
);

   localparam int AW          = $clog2(FIFO_DEPTH);
   localparam int TIMEOUT_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;
   localparam int WD_W        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
   localparam logic [WD_W-1:0] WD_ZERO = {WD_W{1'b0}};
   localparam logic [AW:0]     PTR_ONE = {{AW{1'b0}}, 1'b1};
`ifdef PS2_ASCII_EN
   localparam int ENTRY_W = 18;
`else
   localparam int ENTRY_W = 10;
`endif

   logic [1:0]      clk_sync_r;
   logic [1:0]      data_sync_r;
   logic [2:0]      clk_hist_r;
   logic [3:0]      clk_win_s;
   logic            filt_r;
   logic            filt_prev_r;
   logic            fall_s;
   logic            data_s;

   ps2_state_t      state_r;
   logic [7:0]      shift_r;
   logic [2:0]      bit_cnt_r;
   logic            parity_r;
   logic [WD_W-1:0] wd_cnt_r;
   logic            good_r;
   logic            err_r;
   logic [7:0]      frame_byte_r;

   logic            ext_r;
   logic            brk_r;
   logic            push_s;
   ps2_event_t      ev_s;
   logic [ENTRY_W-1:0] wdata_s;

   logic [ENTRY_W-1:0] mem_r [FIFO_DEPTH];
   logic [AW:0]     wr_ptr_r;
   logic [AW:0]     rd_ptr_r;
   logic            empty_s;
   logic            full_s;
   logic            pop_s;
   logic            do_push_s;
   logic            ovf_set_s;
   logic [ENTRY_W-1:0] head_s;
   logic            overflow_r;
   logic            frame_err_r;

   // Two-flop synchronisers on both PS/2 pins (idle level is high)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync_r  <= 2'b11;
         data_sync_r <= 2'b11;
      end else begin
         clk_sync_r  <= {clk_sync_r[0], ps2_clk};
         data_sync_r <= {data_sync_r[0], ps2_data};
      end
   end

   assign clk_win_s = {clk_hist_r, clk_sync_r[1]};
   assign fall_s    = filt_prev_r & ~filt_r;
   assign data_s    = data_sync_r[1];

   // Glitch filter: filtered clock moves only after 4 equal synced samples
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_hist_r  <= 3'b111;
         filt_r      <= 1'b1;
         filt_prev_r <= 1'b1;
      end else begin
         clk_hist_r  <= clk_win_s[2:0];
         filt_prev_r <= filt_r;
         if (&clk_win_s) begin
            filt_r <= 1'b1;
         end else if (~|clk_win_s) begin
            filt_r <= 1'b0;
         end else begin
            filt_r <= filt_r;
         end
      end
   end

   // Frame FSM with inter-edge watchdog; emits one-cycle good/error pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         shift_r      <= 8'h00;
         bit_cnt_r    <= 3'd0;
         parity_r     <= 1'b0;
         wd_cnt_r     <= WD_ZERO;
         good_r       <= 1'b0;
         err_r        <= 1'b0;
         frame_byte_r <= 8'h00;
      end else begin
         good_r <= 1'b0;
         err_r  <= 1'b0;
         if (state_r != IDLE && !fall_s) begin
            if (wd_cnt_r == WD_ZERO) begin
               state_r <= IDLE;
               err_r   <= 1'b1;
            end else begin
               wd_cnt_r <= wd_cnt_r - WD_ONE;
            end
         end else if (fall_s) begin
            wd_cnt_r <= WD_LOAD;
            case (state_r)
               IDLE: begin
                  if (!data_s) begin
                     state_r   <= DATA;
                     bit_cnt_r <= 3'd0;
                  end
               end
               DATA: begin
                  shift_r   <= {data_s, shift_r[7:1]};
                  bit_cnt_r <= bit_cnt_r + 3'd1;
                  if (bit_cnt_r == 3'd7) begin
                     state_r <= PARITY;
                  end
               end
               PARITY: begin
                  parity_r <= data_s;
                  state_r  <= STOP;
               end
               STOP: begin
                  state_r <= IDLE;
                  if (data_s && odd_parity_ok(shift_r, parity_r)) begin
                     good_r       <= 1'b1;
                     frame_byte_r <= shift_r;
                  end else begin
                     err_r <= 1'b1;
                  end
               end
               default: state_r <= IDLE;
            endcase
         end
      end
   end

   assign push_s   = good_r && (frame_byte_r != PS2_EXT) && (frame_byte_r != PS2_BRK);
   assign ev_s.brk  = brk_r;
   assign ev_s.ext  = ext_r;
   assign ev_s.code = frame_byte_r;

   // Prefix folding: E0/F0 arm flags, any other byte consumes them
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ext_r <= 1'b0;
         brk_r <= 1'b0;
      end else if (good_r) begin
         if (frame_byte_r == PS2_EXT) begin
            ext_r <= 1'b1;
         end else if (frame_byte_r == PS2_BRK) begin
            brk_r <= 1'b1;
         end else begin
            ext_r <= 1'b0;
            brk_r <= 1'b0;
         end
      end
   end

`ifdef PS2_ASCII_EN
   logic       lshift_r;
   logic       rshift_r;
   logic       caps_r;
   logic [7:0] xlat_s;
   logic [7:0] ascii_push_s;

   ps2_set2_ascii u_xlat (
      .code  (frame_byte_r),
      .shift (lshift_r | rshift_r),
      .ascii (xlat_s)
   );

   // Modifier tracking from non-extended shift make/break and caps make
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lshift_r <= 1'b0;
         rshift_r <= 1'b0;
         caps_r   <= 1'b0;
      end else if (push_s && !ext_r) begin
         if (frame_byte_r == PS2_LSHIFT) begin
            lshift_r <= !brk_r;
         end else if (frame_byte_r == PS2_RSHIFT) begin
            rshift_r <= !brk_r;
         end else if (frame_byte_r == PS2_CAPS && !brk_r) begin
            caps_r <= !caps_r;
         end
      end
   end

   // Extended keys carry no ASCII; caps lock flips letter case only
   always_comb begin
      ascii_push_s = 8'h00;
      if (ext_r) begin
         ascii_push_s = 8'h00;
      end else if (caps_r && is_alpha(xlat_s)) begin
         ascii_push_s = xlat_s ^ 8'h20;
      end else begin
         ascii_push_s = xlat_s;
      end
   end

   assign wdata_s  = {ascii_push_s, ev_s};
   assign rd_ascii = head_s[17:10];
`else
   assign wdata_s  = ev_s;
   assign rd_ascii = 8'h00;
`endif

   assign empty_s   = (wr_ptr_r == rd_ptr_r);
   assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign pop_s     = rd_en && !empty_s;
   assign do_push_s = push_s && (!full_s || pop_s);
   assign ovf_set_s = push_s && full_s && !pop_s;
   assign head_s    = mem_r[rd_ptr_r[AW-1:0]];

   // Event FIFO storage and pointers; a pop frees the slot a full push needs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= {ENTRY_W{1'b0}};
         end
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata_s;
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Sticky error flags: a new error wins over a coincident clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_r  <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         if (ovf_set_s) begin
            overflow_r <= 1'b1;
         end else if (clr_err) begin
            overflow_r <= 1'b0;
         end
         if (err_r) begin
            frame_err_r <= 1'b1;
         end else if (clr_err) begin
            frame_err_r <= 1'b0;
         end
      end
   end

   assign rd_valid  = !empty_s;
   assign rd_code   = head_s[7:0];
   assign rd_ext    = head_s[8];
   assign rd_brk    = head_s[9];
   assign overflow  = overflow_r;
   assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx. Runs with a 1 MHz clk so the 1 ms watchdog
// is 1000 cycles; PS/2 clock is 12.5 kHz (80 clk per bit).
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

   logic       clk;
   logic       reset_n;
   logic       ps2_clk;
   logic       ps2_data;
   logic       rd_en;
   logic       rd_valid;
   logic [7:0] rd_code;
   logic       rd_brk;
   logic       rd_ext;
   logic [7:0] rd_ascii;
   logic       overflow;
   logic       frame_err;
   logic       clr_err;

   int vectors = 0;
   int errors  = 0;

   ps2_kbd_rx #(
      .CLK_HZ     (1000000),
      .FIFO_DEPTH (8),
      .TIMEOUT_US (1000)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rd_en     (rd_en),
      .rd_valid  (rd_valid),
      .rd_code   (rd_code),
      .rd_brk    (rd_brk),
      .rd_ext    (rd_ext),
      .rd_ascii  (rd_ascii),
      .overflow  (overflow),
      .frame_err (frame_err),
      .clr_err   (clr_err)
   );

   initial clk = 1'b0;
   always #500 clk = ~clk;

   // Drive the first nbits of a frame; optionally pulse rd_en so it lands in
   // the same clk as the push (2-FF sync + 4-sample filter + edge + 2 clk).
   task automatic send_frame(input logic [7:0] code, input logic bad_par,
                             input logic pop_at_stop, input int nbits);
      logic [10:0] bits;
      bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk) ps2_data = bits[i];
         repeat (20) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == 10 && pop_at_stop) begin
            repeat (7) @(posedge clk);
            @(negedge clk) rd_en = 1'b1;
            @(negedge clk) rd_en = 1'b0;
            repeat (31) @(negedge clk);
         end else begin
            repeat (40) @(negedge clk);
         end
         ps2_clk = 1'b1;
         repeat (20) @(negedge clk);
      end
      ps2_data = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic pop;
      @(negedge clk) rd_en = 1'b1;
      @(negedge clk) rd_en = 1'b0;
   endtask

   task automatic pulse_clr;
      @(negedge clk) clr_err = 1'b1;
      @(negedge clk) clr_err = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rd_valid); end
      vectors++; if ({rd_code, rd_brk, rd_ext, rd_ascii} !== 18'h0) begin errors++; $display("FAIL reset_head got %h want 0", {rd_code, rd_brk, rd_ext, rd_ascii}); end
      vectors++; if ({overflow, frame_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {overflow, frame_err}); end
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_basic;
      logic [7:0] exp_a;
`ifdef PS2_ASCII_EN
      exp_a = 8'h61;
`else
      exp_a = 8'h00;
`endif
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      vectors++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", rd_valid); end
      vectors++; if ({rd_brk, rd_ext, rd_code} !== 10'h01C) begin errors++; $display("FAIL basic_event got %h want 01c", {rd_brk, rd_ext, rd_code}); end
      vectors++; if (rd_ascii !== exp_a) begin errors++; $display("FAIL basic_ascii got %h want %h", rd_ascii, exp_a); end
      vectors++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_ferr got %b want 0", frame_err); end
      pop;
      vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_pop got %b want 0", rd_valid); end
   endtask

   task automatic test_prefix;
      send_frame(8'hE0, 1'b0, 1'b0, 11);
      send_frame(8'hF0, 1'b0, 1'b0, 11);
      vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL prefix_noentry got %b want 0", rd_valid); end
      send_frame(8'h75, 1'b0, 1'b0, 11);
      vectors++; if ({rd_valid, rd_brk, rd_ext, rd_code} !== 11'h775) begin errors++; $display("FAIL prefix_event got %h want 775", {rd_valid, rd_brk, rd_ext, rd_code}); end
      pop;
      vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL prefix_single got %b want 0", rd_valid); end
      send_frame(8'h75, 1'b0, 1'b0, 11);
      vectors++; if ({rd_valid, rd_brk, rd_ext, rd_code} !== 11'h475) begin errors++; $display("FAIL prefix_cleared got %h want 475", {rd_valid, rd_brk, rd_ext, rd_code}); end
      pop;
   endtask

   task automatic test_parity_err;
      send_frame(8'h1C, 1'b1, 1'b0, 11);
      vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL parity_noentry got %b want 0", rd_valid); end
      vectors++; if (frame_err !== 1'b1) begin errors++; $display("FAIL parity_ferr got %b want 1", frame_err); end
      pulse_clr;
      vectors++; if (frame_err !== 1'b0) begin errors++; $display("FAIL parity_clr got %b want 0", frame_err); end
   endtask

   task automatic test_overflow;
      for (int i = 0; i < 9; i++) send_frame(8'h16 + 8'(i), 1'b0, 1'b0, 11);
      vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
      for (int i = 0; i < 8; i++) begin
         vectors++; if ({rd_valid, rd_code} !== {1'b1, 8'h16 + 8'(i)}) begin errors++; $display("FAIL ovf_read%0d got %h want %h", i, {rd_valid, rd_code}, {1'b1, 8'h16 + 8'(i)}); end
         pop;
      end
      vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", rd_valid); end
      pop;
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      vectors++; if ({rd_valid, rd_code} !== 9'h11C) begin errors++; $display("FAIL empty_pop_ignored got %h want 11c", {rd_valid, rd_code}); end
      pop;
      pulse_clr;
      vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", overflow); end
   endtask

   task automatic test_full_push_pop;
      for (int i = 0; i < 8; i++) send_frame(8'h16 + 8'(i), 1'b0, 1'b0, 11);
      vectors++; if ({overflow, rd_valid, rd_code} !== 10'h116) begin errors++; $display("FAIL full_state got %h want 116", {overflow, rd_valid, rd_code}); end
      send_frame(8'h1E, 1'b0, 1'b1, 11);
      vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_nodrop got %b want 0", overflow); end
      for (int i = 0; i < 8; i++) begin
         vectors++; if ({rd_valid, rd_code} !== {1'b1, 8'h17 + 8'(i)}) begin errors++; $display("FAIL full_read%0d got %h want %h", i, {rd_valid, rd_code}, {1'b1, 8'h17 + 8'(i)}); end
         pop;
      end
      vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", rd_valid); end
   endtask

   task automatic test_timeout;
      send_frame(8'h1C, 1'b0, 1'b0, 5);
      repeat (1100) @(negedge clk);
      vectors++; if ({rd_valid, frame_err} !== 2'b01) begin errors++; $display("FAIL timeout got %b want 01", {rd_valid, frame_err}); end
      pulse_clr;
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      vectors++; if ({rd_valid, rd_code, frame_err} !== 10'h238) begin errors++; $display("FAIL timeout_recover got %h want 238", {rd_valid, rd_code, frame_err}); end
      pop;
   endtask

   task automatic test_ascii;
      logic [7:0] exp_a;
`ifdef PS2_ASCII_EN
      exp_a = 8'h41;
`else
      exp_a = 8'h00;
`endif
      send_frame(8'h12, 1'b0, 1'b0, 11);
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      vectors++; if ({rd_valid, rd_code, rd_ascii} !== 17'h11200) begin errors++; $display("FAIL ascii_shift_ev got %h want 11200", {rd_valid, rd_code, rd_ascii}); end
      pop;
      vectors++; if ({rd_valid, rd_code, rd_ascii} !== {9'h11C, exp_a}) begin errors++; $display("FAIL ascii_upper got %h want %h", {rd_valid, rd_code, rd_ascii}, {9'h11C, exp_a}); end
      pop;
      send_frame(8'hF0, 1'b0, 1'b0, 11);
      send_frame(8'h12, 1'b0, 1'b0, 11);
      vectors++; if ({rd_valid, rd_brk, rd_code} !== 10'h312) begin errors++; $display("FAIL ascii_release got %h want 312", {rd_valid, rd_brk, rd_code}); end
      pop;
   endtask

   task automatic test_reset_mid_frame;
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      send_frame(8'h1C, 1'b1, 1'b0, 11);
      vectors++; if ({rd_valid, frame_err} !== 2'b11) begin errors++; $display("FAIL pre_reset got %b want 11", {rd_valid, frame_err}); end
      send_frame(8'h1C, 1'b0, 1'b0, 4);
      @(negedge clk) reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      vectors++; if ({rd_valid, rd_code, rd_brk, rd_ext, rd_ascii, overflow, frame_err} !== 21'h0) begin errors++; $display("FAIL mid_reset got %h want 0", {rd_valid, rd_code, rd_brk, rd_ext, rd_ascii, overflow, frame_err}); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_prefix;
      test_parity_err;
      test_overflow;
      test_full_push_pop;
      test_timeout;
      test_ascii;
      test_reset_mid_frame;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
